// File: rtl/frame_unpacker.sv
// Receive side of the {data, REP x tag} packed-word format: checks tag copies, splits data/tag,
// buffers good words in a first-word-fall-through FIFO. Optional macro: FRAME_UNPACKER_ERRCNT_EN.
module frame_unpacker #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4,
  parameter int REP    = 2,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W+REP*TAG_W-1:0]   in_word,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [TAG_W-1:0]              out_tag,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          err,
  output logic [7:0]                    err_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int WORD_W = DATA_W + REP * TAG_W;
  localparam int ENT_W  = DATA_W + TAG_W;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready and out_valid come only from registers, so neither side sees a
  // combinational path from the other side's handshake inputs.

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [TAG_W-1:0]  r_out_tag;
  logic              r_err;

  logic [DATA_W-1:0] w_data;
  logic [TAG_W-1:0]  w_tag0;
  logic [ENT_W-1:0]  w_entry;
  logic              w_good;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_reject;
  logic [LVL_W-1:0]  w_level_nxt;
  logic [PTR_W-1:0]  w_rd_ptr_inc;
  logic [ENT_W-1:0]  w_head_nxt;

  assign w_data   = in_word[WORD_W-1 -: DATA_W];
  assign w_tag0   = in_word[TAG_W-1:0];
  assign w_entry  = {w_data, w_tag0};
  assign w_accept = in_valid && r_in_ready;
  assign w_push   = w_accept && w_good;
  assign w_reject = w_accept && !w_good;
  assign w_pop    = r_out_valid && out_ready;
  assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);

  always_comb begin
    w_good = 1'b1;
    for (int i = 1; i < REP; i++) begin
      if (in_word[i*TAG_W +: TAG_W] != w_tag0) w_good = 1'b0;
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Next head entry; with one entry left and a simultaneous push, the new word
  // bypasses the memory so it becomes the head without an extra cycle.
  always_comb begin
    w_head_nxt = {r_out_data, r_out_tag};
    if (w_pop) begin
      if (r_level > LVL_W'(1))
        w_head_nxt = r_mem[w_rd_ptr_inc];
      else if (w_push)
        w_head_nxt = w_entry;
    end else if ((r_level == '0) && w_push) begin
      w_head_nxt = w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      r_level     <= w_level_nxt;
      r_in_ready  <= (w_level_nxt != LVL_W'(DEPTH));
      r_out_valid <= (w_level_nxt != '0);
      {r_out_data, r_out_tag} <= w_head_nxt;
      r_err       <= w_reject;
    end
  end

`ifdef FRAME_UNPACKER_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err_cnt <= 8'd0;
    else if (w_reject && (r_err_cnt != 8'hFF))
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign level     = r_level;
  assign err       = r_err;

endmodule

// File: tb/tb_frame_unpacker.sv
// Directed bench for frame_unpacker: expected FIFO entries go into a queue at acceptance
// time and a negedge monitor checks every popped head against it.
module tb_frame_unpacker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_tag;
  logic [2:0]  level;
  logic        err;
  logic [7:0]  err_cnt;

  logic [11:0] exp_q[$];
  int          total;
  int          bad;

  frame_unpacker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .level     (level),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit word_good(input logic [15:0] w);
    return w[7:4] == w[3:0];
  endfunction

  // scoreboard monitor: a pop happens at the next posedge when valid && ready now
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got %0h expected none", {out_data, out_tag});
      end else begin
        check("pop_entry", {20'd0, out_data, out_tag}, {20'd0, exp_q.pop_front()});
      end
    end
  end

  // driver: leaves in_valid high on return so back-to-back calls stream one word per cycle
  task automatic send_word(input logic [15:0] w);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_word  = w;
    for (int k = 0; k < 40 && !accepted; k++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        if (word_good(w)) exp_q.push_back({w[15:8], w[3:0]});
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_cnt;

  initial begin
    total     = 0;
    bad       = 0;
    exp_cnt   = 8'd0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = 16'h0000;
    out_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);

    // 1: single good word, fall-through in one cycle
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_word(16'hFA22);
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_out_valid", out_valid, 1);
    check("t1_data", out_data, 8'hFA);
    check("t1_tag", out_tag, 4'h2);
    check("t1_err", err, 0);
    @(negedge clk);
    check("t1_level_after_pop", level, 0);
    check("t1_valid_after_pop", out_valid, 0);
    check("t1_data_held", out_data, 8'hFA);

    // 2: mismatched tag copies are rejected with a one-cycle err pulse
    @(posedge clk); #1;
    send_word(16'hFA23);
    in_valid = 1'b0;
`ifdef FRAME_UNPACKER_ERRCNT_EN
    exp_cnt = 8'd1;
`endif
    @(negedge clk);
    check("t2_err_pulse", err, 1);
    check("t2_out_valid", out_valid, 0);
    check("t2_level", level, 0);
    check("t2_err_cnt", err_cnt, exp_cnt);
    @(negedge clk);
    check("t2_err_low", err, 0);

    // 3: fill to full, 5th word held off, then ordered drain
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_word(16'h0111);
    send_word(16'h0222);
    send_word(16'h0333);
    send_word(16'h0444);
    in_word = 16'h0555;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_full_level", level, 4);
      check("t3_full_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check("t3_level_empty", level, 0);
    check("t3_last_data", out_data, 8'h04);
    check("t3_last_tag", out_tag, 4'h4);

    // 4: streaming across pointer wrap, level never above 1
    for (int i = 0; i < 12; i++) begin
      logic [3:0] t;
      t = 4'(i + 3);
      send_word({8'(8'h30 + i), t, t});
      check("t4_level_le1", {31'd0, level <= 3'd1}, 1);
    end
    in_valid = 1'b0;
    wait_drain();
    check("t4_level_end", level, 0);

    // 5: async reset with three buffered entries discards them
    out_ready = 1'b0;
    send_word(16'h1177);
    send_word(16'h2288);
    send_word(16'h3399);
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_level3", level, 3);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t5_rst_level", level, 0);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_data", out_data, 0);
    check("t5_rst_tag", out_tag, 0);
    check("t5_rst_err_cnt", err_cnt, 0);
    exp_q.delete();
    exp_cnt = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready_again", in_ready, 1);
    check("t5_empty", out_valid, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_word(16'hAB55);
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_data", out_data, 8'hAB);
    check("t5_tag", out_tag, 4'h5);
    wait_drain();

`ifdef FRAME_UNPACKER_ERRCNT_EN
    // 6: counter saturates at 255
    for (int i = 0; i < 300; i++) send_word(16'h0012 + 16'(i % 3) * 16'h0100);
    in_valid = 1'b0;
    @(negedge clk);
    check("t6_err_cnt_sat", err_cnt, 8'hFF);
    check("t6_no_push", level, 0);
    repeat (3) @(negedge clk);
    check("t6_err_cnt_stable", err_cnt, 8'hFF);
`endif

    repeat (2) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
